imem_loader_ctrl: RTL and testbench
===================================

Name: imem_loader_ctrl

Overview:
- Sequences writes into the 64-word instruction memory and shares its single address port between CPU fetch and a byte-serial program loader.
- In normal operation the PC word address passes straight through to the memory. During a load the CPU is held, incoming bytes are packed into 32-bit words, and each word is written at consecutive word addresses starting at 0.
- On completion the block pulses a CPU restart so fetch resumes at word 0.

Parameters:
- ADDR_W, 6, instruction memory word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, instruction word width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader byte; big-endian, so the first byte of a word lands in bits 31:24.
- ld_last  in  1  qualifies ld_byte as the final data byte of the program.
- ld_ready  out  1  block accepts ld_byte this cycle.
- cpu_pc_addr  in  ADDR_W  fetch word address from the CPU (PC[7:2]).
- cpu_hold  out  1  stalls the CPU (PC/register writes) while high.
- cpu_restart  out  1  one-cycle pulse; CPU resets its PC to 0.
- mi_address  out  ADDR_W  address to instruction memory.
- mi_we  out  1  instruction memory write enable.
- mi_wdata  out  32  instruction memory write data.
- ld_busy  out  1  load in progress.
- ld_done  out  1  one-cycle pulse when a load ends, whether successful or not.
- ld_err  out  1  sticky error flag; cleared on an accepted ld_start.

Behaviour:
- Reset values: state=IDLE, ld_ready=0, cpu_hold=0, cpu_restart=0, mi_we=0, mi_wdata=0, ld_busy=0, ld_done=0, ld_err=0, internal word address=0, byte count=0. mi_address follows cpu_pc_addr.
- IDLE:
  - mi_address = cpu_pc_addr, combinationally.
  - ld_start=1 -> RECV. Clears ld_err, word address=0 and byte count=0.
- RECV:
  - ld_ready=1, cpu_hold=1, ld_busy=1, mi_address = load word address.
  - Byte accepted on ld_valid & ld_ready. It is shifted in (word = {word[23:0], ld_byte}), byte count increments, and the ld_last state is captured.
  - On the 4th accepted byte -> WRITE.
  - ld_last on byte 1-3 (partial word): set ld_err, no write, go to DONE.
- WRITE (exactly 1 cycle):
  - mi_we=1, mi_address = word address, mi_wdata = packed word, ld_ready=0.
  - If last was captured -> CKSUM when CHECKSUM_EN is defined, otherwise -> DONE.
  - Else if word address == 2**ADDR_W-1: overflow, set ld_err, go to DONE.
  - Else increment word address, clear byte count, go to RECV.
- DONE (1 cycle): ld_done=1, cpu_restart=1, cpu_hold=1, then -> IDLE. cpu_hold drops in the IDLE cycle that follows.
- Throughput: at most 1 byte per cycle, so a word takes at least 5 cycles (4 accept cycles + 1 write cycle).
- ld_start outside IDLE is ignored. ld_valid in IDLE, WRITE or DONE is not accepted (ld_ready=0).
- Reset mid-load: return to IDLE immediately and discard any partial word. Words already written stay in memory. cpu_restart is not pulsed.
- mi_we is never high outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum of all data bytes is kept, cleared on ld_start.
  - After the final WRITE the block enters CKSUM with ld_ready=1 and accepts exactly one byte.
  - If (sum + byte) mod 256 != 0, ld_err is set. Either way the block then goes to DONE.
  - ld_last on the checksum byte is ignored.
- Undefined: no CKSUM state and no sum register; the final WRITE goes directly to DONE.

Decomposition:
- Shared package (mips_pkg):
  - state encoding enum: IDLE, RECV, WRITE, CKSUM, DONE;
  - IMEM_ADDR_W=6;
  - INSTR_W=32.
- Sub-module: imem_byte_packer, containing the shift register, 2-bit byte counter and optional checksum accumulator.
- The FSM and address mux stay in the top module.

Test Plan:
- Reset, then idle with cpu_pc_addr=6'h11 -> mi_address=6'h11, cpu_hold=0, mi_we=0.
- ld_start, then bytes 20 02 00 05 20 03 00 0C with ld_last on the 8th byte ->
  - mi_we at addr 0 with 32'h20020005, then at addr 1 with 32'h2003000C;
  - ld_done and cpu_restart pulse once; ld_err=0.
- Same stream with ld_valid toggling every other cycle -> identical writes; no byte lost or duplicated.
- ld_last on the 3rd byte (AC 67 00) -> no mi_we, ld_err=1, ld_done pulses, block returns to IDLE.
- Stream 65 words (260 bytes) without ld_last -> 64 writes (addresses 0-63), then ld_err=1 and ld_done pulse; no write wraps to address 0.
- Reset asserted after 2 bytes of word 1 -> next cycle IDLE, cpu_hold=0, no cpu_restart. With CHECKSUM_EN defined: bytes 01 02 03 04 + checksum F6 -> ld_err=0; checksum F7 -> ld_err=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader slice.
// Holds the loader FSM encoding and memory geometry.
package mips_pkg;

   localparam int IMEM_ADDR_W = 6;
   localparam int INSTR_W     = 32;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
      CKSUM,
      DONE
   } ld_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Big-endian byte-to-word packer with 2-bit byte counter.
// Optional running checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_byte_packer
   import mips_pkg::*;
#(
   parameter int DATA_W = INSTR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift,
   input  logic [7:0]        data,
   input  logic              last,
   output logic [DATA_W-1:0] word,
   output logic [1:0]        count,
`ifdef IMEM_LOADER_CHECKSUM_EN
   output logic [7:0]        sum,
`endif
   output logic              last_seen
);

   // Shift accepted bytes in MSB-first and track the final-byte flag
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word      <= '0;
         count     <= '0;
         last_seen <= 1'b0;
      end else if (shift) begin
         word  <= {word[DATA_W-9:0], data};
         count <= count + 2'd1;
         if (last) begin
            last_seen <= 1'b1;
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Mod-256 sum of every data byte of the current load
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         sum <= '0;
      end else if (shift) begin
         sum <= sum + data;
      end
   end
`endif

endmodule

// File: rtl/imem_loader_ctrl.sv
// Instruction-memory loader: shares the imem address port between
// CPU fetch and a byte-serial loader. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DATA_W = INSTR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] cpu_pc_addr,
   output logic              cpu_hold,
   output logic              cpu_restart,
   output logic [ADDR_W-1:0] mi_address,
   output logic              mi_we,
   output logic [DATA_W-1:0] mi_wdata,
   output logic              ld_busy,
   output logic              ld_done,
   output logic              ld_err
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   ld_state_t         state;
   ld_state_t         state_nxt;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] word;
   logic [1:0]        count;
   logic              last_seen;
   logic              start_ok;
   logic              accept;
   logic              waddr_inc;
   logic              err_set;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        sum;
   logic [7:0]        ck_total;
`endif

   assign start_ok  = (state == IDLE) && ld_start;
   assign accept    = (state == RECV) && ld_valid;
   assign waddr_inc = (state == WRITE) && !last_seen
                      && (waddr != ADDR_MAX);
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign ck_total  = sum + ld_byte;
`endif

   imem_byte_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok),
      .shift     (accept),
      .data      (ld_byte),
      .last      (ld_last),
      .word      (word),
      .count     (count),
`ifdef IMEM_LOADER_CHECKSUM_EN
      .sum       (sum),
`endif
      .last_seen (last_seen)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and error-event decode
   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (ld_start) begin
               state_nxt = RECV;
            end
         end
         RECV: begin
            if (accept) begin
               if (count == 2'd3) begin
                  state_nxt = WRITE;
               end else if (ld_last) begin
                  err_set   = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         WRITE: begin
            if (last_seen) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = CKSUM;
`else
               state_nxt = DONE;
`endif
            end else if (waddr == ADDR_MAX) begin
               err_set   = 1'b1;
               state_nxt = DONE;
            end else begin
               state_nxt = RECV;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CKSUM: begin
            if (ld_valid) begin
               err_set   = (ck_total != 8'd0);
               state_nxt = DONE;
            end
         end
`endif
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode and address-port mux
   always_comb begin
      ld_ready    = 1'b0;
      cpu_hold    = 1'b1;
      cpu_restart = 1'b0;
      mi_we       = 1'b0;
      mi_wdata    = '0;
      ld_busy     = 1'b0;
      ld_done     = 1'b0;
      mi_address  = waddr;
      case (state)
         IDLE: begin
            cpu_hold   = 1'b0;
            mi_address = cpu_pc_addr;
         end
         RECV: begin
            ld_ready = 1'b1;
            ld_busy  = 1'b1;
         end
         WRITE: begin
            mi_we    = 1'b1;
            mi_wdata = word;
            ld_busy  = 1'b1;
         end
         CKSUM: begin
            ld_ready = 1'b1;
            ld_busy  = 1'b1;
         end
         DONE: begin
            ld_done     = 1'b1;
            cpu_restart = 1'b1;
         end
         default: begin
            cpu_hold = 1'b1;
         end
      endcase
   end

   // Sticky error flag, cleared when a new load is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_err <= 1'b0;
      end else if (start_ok) begin
         ld_err <= 1'b0;
      end else if (err_set) begin
         ld_err <= 1'b1;
      end
   end

   // Load word address, restarts at 0 for every load
   always_ff @(posedge clk) begin
      if (reset) begin
         waddr <= '0;
      end else if (start_ok) begin
         waddr <= '0;
      end else if (waddr_inc) begin
         waddr <= waddr + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scoreboard bench for imem_loader_ctrl: a word-level load model
// queues expected writes and completion status; a monitor checks them.
module tb_imem_loader_ctrl;
   import mips_pkg::*;

   typedef logic [7:0] q8_t[$];
   typedef struct {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_last;
   logic        ld_ready;
   logic [5:0]  cpu_pc_addr;
   logic        cpu_hold;
   logic        cpu_restart;
   logic [5:0]  mi_address;
   logic        mi_we;
   logic [31:0] mi_wdata;
   logic        ld_busy;
   logic        ld_done;
   logic        ld_err;

   int   nchk = 0;
   int   nerr = 0;
   int   done_cnt = 0;
   int   restart_cnt = 0;
   wr_t  wq[$];
   logic eq[$];
   wr_t  mon_e;

   always #5 clk = ~clk;

   imem_loader_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_byte     (ld_byte),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .cpu_pc_addr (cpu_pc_addr),
      .cpu_hold    (cpu_hold),
      .cpu_restart (cpu_restart),
      .mi_address  (mi_address),
      .mi_we       (mi_we),
      .mi_wdata    (mi_wdata),
      .ld_busy     (ld_busy),
      .ld_done     (ld_done),
      .ld_err      (ld_err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: pops expected writes and completions as the DUT shows them
   always @(negedge clk) begin
      if (!reset) begin
         if (mi_we) begin
            if (wq.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_write: got addr %h data %h want none",
                        mi_address, mi_wdata);
            end else begin
               mon_e = wq.pop_front();
               chk("wr_addr", {26'd0, mi_address}, {26'd0, mon_e.a});
               chk("wr_data", mi_wdata, mon_e.d);
            end
         end
         if (cpu_restart) restart_cnt++;
         if (ld_done) begin
            done_cnt++;
            chk("restart_with_done", {31'd0, cpu_restart}, 32'd1);
            if (eq.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_done: got done want none");
            end else begin
               chk("ld_err", {31'd0, ld_err}, {31'd0, eq.pop_front()});
            end
         end
      end
   end

   // Reference model + driver for one load.
   // L: index of the byte flagged ld_last (-1 = never).
   // mode: 0 always valid, 1 every other cycle, 2 random.
   task automatic run_load(input q8_t b, input int L,
                           input logic [7:0] ck, input int mode);
      int   nb;
      int   nw;
      int   writes;
      bit   partial;
      logic err;
      q8_t  s;
      int   idx;
      int   cyc;
      int   d0;
      int   r0;
      logic v;
      logic r;
      logic [7:0] sum;
      nb      = (L < 0) ? b.size() : L + 1;
      nw      = nb / 4;
      partial = (L >= 0) && (nb % 4 != 0);
      writes  = (nw > 64) ? 64 : nw;
      err     = partial || (L < 0) || (nw > 64);
      for (int w = 0; w < writes; w++) begin
         wq.push_back('{a: w[5:0],
                        d: {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]}});
      end
      s = b;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!err) begin
         sum = 8'd0;
         for (int i = 0; i <= L; i++) sum = sum + b[i];
         err = ((sum + ck) != 8'd0);
         s.push_back(ck);
      end
`else
      sum = ck;
`endif
      eq.push_back(err);
      d0 = done_cnt;
      r0 = restart_cnt;
      @(negedge clk);
      ld_start = 1'b1;
      @(posedge clk);
      idx = 0;
      cyc = 0;
      forever begin
         @(negedge clk);
         ld_start = 1'b0;
         if (!ld_busy || idx >= s.size()) begin
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            break;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = cyc[0];
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         ld_valid = v;
         ld_byte  = s[idx];
         ld_last  = (idx == L);
         r        = ld_ready;
         @(posedge clk);
         if (v && r) idx++;
         cyc++;
         if (cyc > 5000) begin
            nchk++;
            nerr++;
            $display("FAIL drive_timeout: got %0d bytes want %0d", idx,
                     s.size());
            break;
         end
      end
      for (int i = 0; i < 30; i++) begin
         if (done_cnt != d0) break;
         @(posedge clk);
      end
      repeat (3) @(posedge clk);
      chk("done_once", done_cnt - d0, 32'd1);
      chk("restart_once", restart_cnt - r0, 32'd1);
      chk("writes_drained", wq.size(), 32'd0);
      #1;
      chk("hold_released", {31'd0, cpu_hold}, 32'd0);
      wq.delete();
      eq.delete();
   endtask

   initial begin
      q8_t  b;
      int   nw;
      int   L;
      logic [7:0] ck;
      logic [7:0] sm;
      int   r0;
      reset       = 1'b1;
      ld_start    = 1'b0;
      ld_valid    = 1'b0;
      ld_byte     = 8'h00;
      ld_last     = 1'b0;
      cpu_pc_addr = 6'h11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_addr", {26'd0, mi_address}, 32'h11);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
      chk("rst_we", {31'd0, mi_we}, 32'd0);
      chk("rst_ready", {31'd0, ld_ready}, 32'd0);
      chk("rst_err", {31'd0, ld_err}, 32'd0);
      chk("rst_done", {30'd0, ld_done, cpu_restart}, 32'd0);
      chk("rst_busy", {31'd0, ld_busy}, 32'd0);
      chk("rst_wdata", mi_wdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_addr", {26'd0, mi_address}, 32'h11);

      b = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};
      run_load(b, 7, 8'h72, 0);
      run_load(b, 7, 8'h72, 1);

      b = '{8'hAC, 8'h67, 8'h00};
      run_load(b, 2, 8'h00, 0);

      b = {};
      for (int i = 0; i < 260; i++) b.push_back(8'($urandom));
      run_load(b, -1, 8'h00, 0);

      for (int t = 0; t < 8; t++) begin
         nw = $urandom_range(1, 12);
         b  = {};
         for (int i = 0; i < 4 * nw; i++) b.push_back(8'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            L = 4 * (nw - 1) + $urandom_range(0, 2);
            while (b.size() > L + 1) void'(b.pop_back());
         end else begin
            L = 4 * nw - 1;
         end
         sm = 8'd0;
         for (int i = 0; i < b.size(); i++) sm = sm + b[i];
         ck = 8'd0 - sm + 8'($urandom_range(0, 1));
         run_load(b, L, ck, 2);
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      b = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_load(b, 3, 8'hF6, 0);
      chk("cksum_ok_err", {31'd0, ld_err}, 32'd0);
      run_load(b, 3, 8'hF7, 0);
      chk("cksum_bad_err", {31'd0, ld_err}, 32'd1);
`endif

      r0 = restart_cnt;
      @(negedge clk);
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
      ld_valid = 1'b1;
      ld_byte  = 8'h12;
      @(negedge clk);
      ld_byte  = 8'h34;
      @(negedge clk);
      ld_valid = 1'b0;
      chk("mid_busy", {31'd0, ld_busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
      chk("mid_rst_busy", {31'd0, ld_busy}, 32'd0);
      chk("mid_rst_ready", {31'd0, ld_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      chk("mid_rst_norestart", restart_cnt - r0, 32'd0);

      b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      sm = 8'hDE + 8'hAD + 8'hBE + 8'hEF;
      run_load(b, 3, 8'd0 - sm, 1);

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cpu_pc_addr = 6'($urandom);
         #1;
         chk("idle_passthru", {26'd0, mi_address}, {26'd0, cpu_pc_addr});
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
